// File: rtl/dps_timer_unit.sv
// 64-bit timer/compare peripheral on the DPS register bus.
// Reads return through a small response FIFO; compare matches raise a held IRQ.
module dps_timer_unit #(
    parameter int         P_RESP_DEPTH = 4,
    parameter int         P_PRESCALE   = 1,
    parameter logic [5:0] P_IRQ_NUM    = 6'h1
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iDPS_REQ,
    output logic        oDPS_BUSY,
    input  logic        iDPS_RW,
    input  logic [31:0] iDPS_ADDR,
    input  logic [31:0] iDPS_DATA,
    output logic        oDPS_VALID,
    input  logic        iDPS_BUSY,
    output logic [31:0] oDPS_DATA,
    output logic        oDPS_IRQ_REQ,
    output logic [5:0]  oDPS_IRQ_NUM,
    input  logic        iDPS_IRQ_ACK
);

    localparam int AW = $clog2(P_RESP_DEPTH);
    localparam int PW = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(P_PRESCALE - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(P_RESP_DEPTH);

    typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_state_t;

    logic        en, irqen, periodic, hit;
    logic [63:0] count, cmp;
    logic [31:0] per, shadow;
    logic [PW-1:0] presc;
    irq_state_t  irq_state;
    logic        irq_req;

    logic [31:0] mem [P_RESP_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   level;

    logic        accept, wr, rd, in_map;
    logic [2:0]  idx;
    logic        wr_ctrl, wr_stat, wr_cntl, wr_cnth, wr_cmpl, wr_cmph, wr_per, rd_cntl;
    logic        cnt_wr, cmp_wr, tick, match, qualify, irqen_nxt;
    logic        push, pop;
    logic [63:0] count_inc;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^iDPS_ADDR[1:0];

    assign oDPS_BUSY    = (level == FULL);
    assign oDPS_VALID   = (level != '0);
    assign oDPS_DATA    = mem[rptr];
    assign oDPS_IRQ_REQ = irq_req;
    assign oDPS_IRQ_NUM = P_IRQ_NUM;

    // Address decode: only word offsets 0x00..0x18 map to registers
    assign accept = iDPS_REQ && !oDPS_BUSY;
    assign wr     = accept && iDPS_RW;
    assign rd     = accept && !iDPS_RW;
    assign idx    = iDPS_ADDR[4:2];
    assign in_map = (iDPS_ADDR[31:5] == '0) && (idx != 3'd7);

    assign wr_ctrl = wr && in_map && (idx == 3'd0);
    assign wr_stat = wr && in_map && (idx == 3'd1);
    assign wr_cntl = wr && in_map && (idx == 3'd2);
    assign wr_cnth = wr && in_map && (idx == 3'd3);
    assign wr_cmpl = wr && in_map && (idx == 3'd4);
    assign wr_cmph = wr && in_map && (idx == 3'd5);
    assign wr_per  = wr && in_map && (idx == 3'd6);
    assign rd_cntl = rd && in_map && (idx == 3'd2);

    always_comb begin
        rdata = '0;
        if (in_map) begin
            case (idx)
                3'd0:    rdata = {29'd0, periodic, irqen, en};
                3'd1:    rdata = {31'd0, hit};
                3'd2:    rdata = count[31:0];
                3'd3:    rdata = shadow;
                3'd4:    rdata = cmp[31:0];
                3'd5:    rdata = cmp[63:32];
                3'd6:    rdata = per;
                default: rdata = '0;
            endcase
        end
    end

    // A CPU counter write suppresses the tick and restarts the prescaler
    assign cnt_wr    = wr_cntl || wr_cnth;
    assign cmp_wr    = wr_cmpl || wr_cmph;
    assign tick      = en && !cnt_wr && (presc == PRE_LAST);
    assign count_inc = count + 64'd1;
    assign match     = tick && (count_inc == cmp);
    assign qualify   = match && irqen;
    assign irqen_nxt = wr_ctrl ? iDPS_DATA[1] : irqen;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            en       <= 1'b0;
            irqen    <= 1'b0;
            periodic <= 1'b0;
            hit      <= 1'b0;
            count    <= '0;
            cmp      <= '0;
            per      <= '0;
            shadow   <= '0;
            presc    <= '0;
        end else begin
            if (!en || cnt_wr || presc == PRE_LAST)
                presc <= '0;
            else
                presc <= presc + PW'(1);

            if (tick)
                count <= count_inc;
            if (wr_cntl)
                count[31:0] <= iDPS_DATA;
            if (wr_cnth)
                count[63:32] <= iDPS_DATA;
            if (rd_cntl)
                shadow <= count[63:32];

            if (cmp_wr) begin
                if (wr_cmpl)
                    cmp[31:0] <= iDPS_DATA;
                if (wr_cmph)
                    cmp[63:32] <= iDPS_DATA;
            end else if (match && periodic) begin
                cmp <= cmp + {32'd0, per};
            end

            if (wr_per)
                per <= iDPS_DATA;
            if (wr_ctrl)
                {periodic, irqen, en} <= iDPS_DATA[2:0];

            if (match)
                hit <= 1'b1;
            else if (wr_stat && iDPS_DATA[0])
                hit <= 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            irq_state <= IRQ_IDLE;
            irq_req   <= 1'b0;
        end else begin
            case (irq_state)
                IRQ_IDLE: begin
                    if (qualify) begin
                        irq_state <= IRQ_PEND;
                        irq_req   <= 1'b1;
                    end
                end
                IRQ_PEND: begin
                    if (!irqen_nxt || (iDPS_IRQ_ACK && !qualify)) begin
                        irq_state <= IRQ_IDLE;
                        irq_req   <= 1'b0;
                    end
                end
                default: begin
                    irq_state <= IRQ_IDLE;
                    irq_req   <= 1'b0;
                end
            endcase
        end
    end

    // Response FIFO; accept is gated by full, so push never overruns
    assign push = rd;
    assign pop  = oDPS_VALID && !iDPS_BUSY;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < P_RESP_DEPTH; i++)
                mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= rdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_dps_timer_unit.sv
// Directed bench for dps_timer_unit: per-cycle comparison against a register-level
// model plus literal expectations for the key scenarios.
module tb_dps_timer_unit;

    localparam int DEPTH = 4;
    localparam int PRE   = 2;

    logic        iCLOCK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iDPS_REQ = 1'b0;
    logic        iDPS_RW = 1'b0;
    logic [31:0] iDPS_ADDR = '0;
    logic [31:0] iDPS_DATA = '0;
    logic        iDPS_BUSY = 1'b0;
    logic        iDPS_IRQ_ACK = 1'b0;
    logic        oDPS_BUSY, oDPS_VALID, oDPS_IRQ_REQ;
    logic [31:0] oDPS_DATA;
    logic [5:0]  oDPS_IRQ_NUM;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    dps_timer_unit #(.P_RESP_DEPTH(DEPTH), .P_PRESCALE(PRE), .P_IRQ_NUM(6'h1)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET),
        .iDPS_REQ(iDPS_REQ), .oDPS_BUSY(oDPS_BUSY), .iDPS_RW(iDPS_RW),
        .iDPS_ADDR(iDPS_ADDR), .iDPS_DATA(iDPS_DATA),
        .oDPS_VALID(oDPS_VALID), .iDPS_BUSY(iDPS_BUSY), .oDPS_DATA(oDPS_DATA),
        .oDPS_IRQ_REQ(oDPS_IRQ_REQ), .oDPS_IRQ_NUM(oDPS_IRQ_NUM),
        .iDPS_IRQ_ACK(iDPS_IRQ_ACK)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Register-level model of the peripheral
    bit [2:0]    m_ctrl;
    bit          m_hit, m_pend;
    bit [63:0]   m_count, m_cmp;
    bit [31:0]   m_per, m_shadow;
    int          m_presc;
    logic [31:0] m_q[$];

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        case (a)
            32'h00:  return {29'd0, m_ctrl};
            32'h04:  return {31'd0, m_hit};
            32'h08:  return m_count[31:0];
            32'h0C:  return m_shadow;
            32'h10:  return m_cmp[31:0];
            32'h14:  return m_cmp[63:32];
            32'h18:  return m_per;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit acc, cnt_wr, cmp_wr, tick, match, qual;
        logic [31:0] a, d;
        a = iDPS_ADDR;
        d = iDPS_DATA;
        acc = iDPS_REQ && (m_q.size() < DEPTH);
        if (m_q.size() > 0 && !iDPS_BUSY)
            void'(m_q.pop_front());
        if (acc && !iDPS_RW)
            m_q.push_back(m_reg(a));
        cnt_wr = acc && iDPS_RW && (a == 32'h08 || a == 32'h0C);
        cmp_wr = acc && iDPS_RW && (a == 32'h10 || a == 32'h14);
        tick   = m_ctrl[0] && !cnt_wr && (m_presc == PRE - 1);
        match  = tick && ((m_count + 64'd1) == m_cmp);
        qual   = match && m_ctrl[1];
        if (acc && !iDPS_RW && a == 32'h08)
            m_shadow = m_count[63:32];
        m_presc = (!m_ctrl[0] || cnt_wr) ? 0 : (m_presc + 1) % PRE;
        if (tick)
            m_count = m_count + 64'd1;
        if (match && m_ctrl[2] && !cmp_wr)
            m_cmp = m_cmp + {32'd0, m_per};
        if (acc && iDPS_RW) begin
            case (a)
                32'h00: m_ctrl = d[2:0];
                32'h04: if (d[0]) m_hit = 1'b0;
                32'h08: m_count[31:0] = d;
                32'h0C: m_count[63:32] = d;
                32'h10: m_cmp[31:0] = d;
                32'h14: m_cmp[63:32] = d;
                32'h18: m_per = d;
                default: ;
            endcase
        end
        if (match)
            m_hit = 1'b1;
        if (!m_pend)
            m_pend = qual;
        else if (!m_ctrl[1] || (iDPS_IRQ_ACK && !qual))
            m_pend = 1'b0;
    endtask

    always @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            m_ctrl = '0; m_hit = 0; m_pend = 0; m_count = '0; m_cmp = '0;
            m_per = '0; m_shadow = '0; m_presc = 0;
            m_q.delete();
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model
    always @(negedge iCLOCK) begin
        if (!iRESET && chk_en) begin
            logic [31:0] exp_d;
            exp_d = (m_q.size() != 0) ? m_q[0] : 32'd0;
            vectors++;
            if (oDPS_BUSY !== (m_q.size() == DEPTH) || oDPS_VALID !== (m_q.size() != 0) ||
                oDPS_IRQ_REQ !== m_pend || oDPS_IRQ_NUM !== 6'h1 ||
                (m_q.size() != 0 && oDPS_DATA !== exp_d)) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t busy=%b/%b valid=%b/%b irq=%b/%b data=%h/%h",
                         $time, oDPS_BUSY, (m_q.size() == DEPTH), oDPS_VALID, (m_q.size() != 0),
                         oDPS_IRQ_REQ, m_pend, oDPS_DATA, exp_d);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        iDPS_REQ = 1'b1; iDPS_RW = 1'b1; iDPS_ADDR = a; iDPS_DATA = d;
        @(negedge iCLOCK);
        iDPS_REQ = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        iDPS_REQ = 1'b1; iDPS_RW = 1'b0; iDPS_ADDR = a;
        @(negedge iCLOCK);
        iDPS_REQ = 1'b0;
        check({name, "_valid"}, {31'd0, oDPS_VALID}, 32'd1);
        check(name, oDPS_DATA, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iCLOCK);
    endtask

    task automatic wait_irq(input string name);
        int c = 0;
        while (!oDPS_IRQ_REQ && c < 200) begin
            @(negedge iCLOCK);
            c++;
        end
        check(name, {31'd0, oDPS_IRQ_REQ}, 32'd1);
    endtask

    task automatic ack_pulse();
        iDPS_IRQ_ACK = 1'b1;
        @(negedge iCLOCK);
        iDPS_IRQ_ACK = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        logic [31:0] rsp   [5];
        int n;
        bit will_acc, got;
        logic [31:0] d;

        idle(2);
        iRESET = 1'b0;
        chk_en = 1'b1;

        // Reset state and register map edges
        check("rst_valid", {31'd0, oDPS_VALID}, 32'd0);
        check("rst_busy", {31'd0, oDPS_BUSY}, 32'd0);
        check("rst_irq", {31'd0, oDPS_IRQ_REQ}, 32'd0);
        check("irq_num", {26'd0, oDPS_IRQ_NUM}, 32'd1);
        rd("rst_ctrl", 32'h00, 32'd0);
        rd("rst_cntl", 32'h08, 32'd0);
        wr(32'h1C, 32'hDEADBEEF);
        rd("unmapped_1c", 32'h1C, 32'd0);
        rd("unmapped_20", 32'h20, 32'd0);
        wr(32'h00, 32'hFFFF_FFF8);
        rd("ctrl_mask", 32'h00, 32'd0);

        // Match without IRQEN: HIT set, no interrupt
        wr(32'h10, 32'd5);
        wr(32'h14, 32'd0);
        wr(32'h00, 32'd1);
        idle(14);
        check("noirq_irqen0", {31'd0, oDPS_IRQ_REQ}, 32'd0);
        rd("hit_set", 32'h04, 32'd1);

        // Periodic interrupts at counts 3, 13, 23
        wr(32'h00, 32'd0);
        wr(32'h04, 32'd1);
        wr(32'h18, 32'd10);
        wr(32'h10, 32'd3);
        wr(32'h14, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'd7);
        wait_irq("irq1");
        rd("cmp_reload1", 32'h10, 32'd13);
        ack_pulse();
        check("irq_drop1", {31'd0, oDPS_IRQ_REQ}, 32'd0);
        wait_irq("irq2");
        rd("cmp_reload2", 32'h10, 32'd23);
        ack_pulse();
        check("irq_drop2", {31'd0, oDPS_IRQ_REQ}, 32'd0);
        wait_irq("irq3");
        rd("cmp_reload3", 32'h10, 32'd33);
        check("irq_num_pend", {26'd0, oDPS_IRQ_NUM}, 32'd1);
        rd("hit_after_ack", 32'h04, 32'd1);
        ack_pulse();
        check("irq_drop3", {31'd0, oDPS_IRQ_REQ}, 32'd0);

        // Response FIFO backpressure
        wr(32'h00, 32'd0);
        wr(32'h04, 32'd1);
        wr(32'h18, 32'h11);
        wr(32'h10, 32'h22);
        wr(32'h14, 32'h33);
        addrs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18};
        exps  = '{32'h00, 32'h00, 32'h22, 32'h33, 32'h11};
        iDPS_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iDPS_REQ = 1'b1; iDPS_RW = 1'b0; iDPS_ADDR = addrs[i];
            @(negedge iCLOCK);
        end
        check("busy_full", {31'd0, oDPS_BUSY}, 32'd1);
        iDPS_ADDR = addrs[4];
        @(negedge iCLOCK);
        check("busy_hold", {31'd0, oDPS_BUSY}, 32'd1);
        iDPS_BUSY = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            will_acc = iDPS_REQ && !oDPS_BUSY;
            got = oDPS_VALID && !iDPS_BUSY;
            d = oDPS_DATA;
            @(negedge iCLOCK);
            if (got) begin
                rsp[n] = d;
                n++;
            end
            if (will_acc)
                iDPS_REQ = 1'b0;
        end
        check("rsp_count", n, 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rsp_order%0d", i), rsp[i], exps[i]);

        // Consistent CNTL/CNTH pair across a carry
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h00, 32'd1);
        rd("pair_lo", 32'h08, 32'hFFFF_FFFF);
        rd("pair_hi", 32'h0C, 32'd0);
        rd("pair2_lo", 32'h08, 32'd0);
        rd("pair2_hi", 32'h0C, 32'd1);

        // 64-bit wrap
        wr(32'h00, 32'd0);
        wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h0C, 32'hFFFF_FFFF);
        wr(32'h00, 32'd1);
        idle(4);
        rd("wrap_lo", 32'h08, 32'd0);
        rd("wrap_hi", 32'h0C, 32'd0);

        // STAT clear coinciding with a match
        wr(32'h00, 32'd0);
        wr(32'h04, 32'd1);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h10, 32'd2);
        wr(32'h14, 32'd0);
        wr(32'h00, 32'd1);
        idle(3);
        wr(32'h04, 32'd1);
        rd("hit_wins_clear", 32'h04, 32'd1);

        // ACK coinciding with a new match
        wr(32'h00, 32'd0);
        wr(32'h04, 32'd1);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h10, 32'd2);
        wr(32'h18, 32'd2);
        wr(32'h00, 32'd7);
        idle(4);
        check("irq_pend_a", {31'd0, oDPS_IRQ_REQ}, 32'd1);
        idle(3);
        ack_pulse();
        check("ack_vs_match", {31'd0, oDPS_IRQ_REQ}, 32'd1);
        ack_pulse();
        check("ack_plain", {31'd0, oDPS_IRQ_REQ}, 32'd0);

        // Asynchronous reset mid-burst
        wait_irq("irq_before_reset");
        iDPS_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iDPS_REQ = 1'b1; iDPS_RW = 1'b0; iDPS_ADDR = 32'h08;
            @(negedge iCLOCK);
        end
        iDPS_REQ = 1'b0;
        check("burst_valid", {31'd0, oDPS_VALID}, 32'd1);
        #2 iRESET = 1'b1;
        #1;
        check("async_valid", {31'd0, oDPS_VALID}, 32'd0);
        check("async_irq", {31'd0, oDPS_IRQ_REQ}, 32'd0);
        check("async_busy", {31'd0, oDPS_BUSY}, 32'd0);
        check("async_data", oDPS_DATA, 32'd0);
        @(negedge iCLOCK);
        iRESET = 1'b0;
        iDPS_BUSY = 1'b0;
        rd("post_rst_cntl", 32'h08, 32'd0);
        rd("post_rst_cnth", 32'h0C, 32'd0);
        rd("post_rst_ctrl", 32'h00, 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
